// File: rtl/ifq_pkg.sv
// ============================================================================
// Module : ifq_pkg
// Brief  : Shared types and constants for the instruction-fetch queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ifq_pkg;

    localparam int IFQ_AWIDTH = 32;
    localparam int IFQ_DWIDTH = 32;

    localparam logic [IFQ_DWIDTH-1:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [IFQ_AWIDTH-1:0] pc;
        logic [IFQ_DWIDTH-1:0] insn;
    } ifq_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifq_fifo.sv
// ============================================================================
// Module : ifq_fifo
// Brief  : Circular-buffer FIFO of {pc, insn} entries with flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  ifq_entry_t                 i_entry,
    input  logic                       i_pop,
    output logic                       o_valid,
    output ifq_entry_t                 o_head,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;

    ifq_entry_t        r_mem [DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;

    logic              w_pop;
    logic              w_push;

    assign w_pop  = i_pop && (r_count != '0);
    // A push into a full queue is only accepted when a pop frees a slot this cycle.
    assign w_push = i_push && ((r_count != c_CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (w_push && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/ifetch_queue.sv
// ============================================================================
// Module : ifetch_queue
// Brief  : Instruction fetch unit with credit-based request issue, redirect
//          flush/drop handling and a decode-facing FIFO. Optional perf
//          counters are enabled with macro IFQ_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int                AWIDTH   = 32,
    parameter int                DWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000,
    parameter int                DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_o,
    output logic [AWIDTH-1:0]   imem_addr_o,
    input  logic                imem_rvalid_i,
    input  logic [DWIDTH-1:0]   imem_insn_i,
    input  logic                redirect_i,
    input  logic [AWIDTH-1:0]   redirect_pc_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [AWIDTH-1:0]   pc_o,
    output logic [DWIDTH-1:0]   insn_o,
    output logic [31:0]         perf_flush_cnt_o,
    output logic [31:0]         perf_starve_cnt_o
);

    localparam int c_CW = $clog2(DEPTH) + 1;

    logic [AWIDTH-1:0] r_fetch_pc;
    logic [AWIDTH-1:0] r_last_addr;
    logic [c_CW-1:0]   r_outstanding;
    logic [c_CW-1:0]   r_drop_cnt;

    logic [c_CW-1:0]   w_count;
    logic [c_CW:0]     w_inflight;
    logic              w_rsp;
    logic              w_push;
    logic              w_valid;
    ifq_entry_t        w_push_entry;
    ifq_entry_t        w_head;
    logic              w_unused;

    // Entries already queued plus reads in flight must leave room for every response.
    assign w_inflight = {1'b0, w_count} + {1'b0, r_outstanding};
    assign imem_req_o = (w_inflight < (c_CW+1)'(DEPTH)) && !redirect_i && !rst;
    assign imem_addr_o = r_fetch_pc;

    assign w_rsp  = imem_rvalid_i && !rst;
    assign w_push = w_rsp && !redirect_i && (r_drop_cnt == '0);

    assign w_push_entry.pc   = r_last_addr;
    assign w_push_entry.insn = imem_insn_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= BASEADDR;
            r_last_addr   <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_i) begin
            r_fetch_pc    <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
            r_outstanding <= r_outstanding - c_CW'(w_rsp);
            r_drop_cnt    <= r_outstanding - c_CW'(w_rsp);
        end else begin
            if (imem_req_o) begin
                r_fetch_pc  <= r_fetch_pc + AWIDTH'(4);
                r_last_addr <= r_fetch_pc;
            end
            r_outstanding <= r_outstanding + c_CW'(imem_req_o) - c_CW'(w_rsp);
            if (w_rsp && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - c_CW'(1);
            end
        end
    end

    ifq_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_i),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (ready_i),
        .o_valid (w_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign valid_o = w_valid;
    assign pc_o    = w_valid ? w_head.pc   : '0;
    assign insn_o  = w_valid ? w_head.insn : '0;

`ifdef IFQ_PERF_EN
    logic [31:0] r_flush_cnt;
    logic [31:0] r_starve_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_cnt  <= '0;
            r_starve_cnt <= '0;
        end else begin
            if (redirect_i && (r_flush_cnt != 32'hFFFFFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
            if (!w_valid && ready_i && (r_starve_cnt != 32'hFFFFFFFF)) begin
                r_starve_cnt <= r_starve_cnt + 32'd1;
            end
        end
    end

    assign perf_flush_cnt_o  = r_flush_cnt;
    assign perf_starve_cnt_o = r_starve_cnt;
`else
    assign perf_flush_cnt_o  = 32'd0;
    assign perf_starve_cnt_o = 32'd0;
`endif

    // Redirect targets are word-aligned, so the low address bits never matter.
    assign w_unused = ^redirect_pc_i[1:0];

endmodule

`default_nettype wire

// File: tb/tb_ifetch_queue.sv
// ============================================================================
// Module : tb_ifetch_queue
// Brief  : Self-checking bench for ifetch_queue with a queue-level reference
//          model and directed scenarios. Honours macro IFQ_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ifetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h01000000;
    localparam logic [31:0] XMASK = 32'hA5A5A5A5;

    logic        clk;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_insn_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic [31:0] perf_flush_cnt_o;
    logic [31:0] perf_starve_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch_queue #(
        .AWIDTH   (32),
        .DWIDTH   (32),
        .BASEADDR (BASE),
        .DEPTH    (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_rvalid_i     (imem_rvalid_i),
        .imem_insn_i       (imem_insn_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .valid_o           (valid_o),
        .ready_i           (ready_i),
        .pc_o              (pc_o),
        .insn_o            (insn_o),
        .perf_flush_cnt_o  (perf_flush_cnt_o),
        .perf_starve_cnt_o (perf_starve_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle-latency memory that shares reset and returns addr ^ XMASK.
    initial imem_rvalid_i = 1'b0;
    initial imem_insn_i   = 32'd0;
    always @(posedge clk) begin
        imem_rvalid_i <= rst ? 1'b0 : imem_req_o;
        imem_insn_i   <= imem_addr_o ^ XMASK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpend[$];
    logic [31:0] m_fpc    = BASE;
    int          m_drop   = 0;
    logic [31:0] m_flush  = 0;
    logic [31:0] m_starve = 0;

    // Reference model: compare on each falling edge, then advance one cycle.
    always @(negedge clk) begin
        bit          ev;
        bit          er;
        logic [31:0] epc;
        logic [31:0] ein;
        logic [31:0] a;
        ev  = (mq.size() != 0);
        epc = ev ? mq[0].pc   : 32'd0;
        ein = ev ? mq[0].insn : 32'd0;
        er  = !rst && !redirect_i && ((mq.size() + mpend.size()) < DEPTH);
        chk("m_req", {31'd0, imem_req_o}, {31'd0, er});
        if (er) chk("m_addr", imem_addr_o, m_fpc);
        chk("m_valid", {31'd0, valid_o}, {31'd0, ev});
        chk("m_pc", pc_o, epc);
        chk("m_insn", insn_o, ein);
`ifdef IFQ_PERF_EN
        chk("m_flush", perf_flush_cnt_o, m_flush);
        chk("m_starve", perf_starve_cnt_o, m_starve);
`else
        chk("m_flush", perf_flush_cnt_o, 32'd0);
        chk("m_starve", perf_starve_cnt_o, 32'd0);
`endif
        if (rst) begin
            mq.delete();
            mpend.delete();
            m_fpc    = BASE;
            m_drop   = 0;
            m_flush  = 0;
            m_starve = 0;
        end else begin
            if (!ev && ready_i && m_starve != 32'hFFFFFFFF) m_starve++;
            if (redirect_i) begin
                if (imem_rvalid_i && mpend.size() != 0) void'(mpend.pop_front());
                m_drop = mpend.size();
                mq.delete();
                m_fpc = redirect_pc_i & ~32'd3;
                if (m_flush != 32'hFFFFFFFF) m_flush++;
            end else begin
                if (ev && ready_i) void'(mq.pop_front());
                if (imem_rvalid_i) begin
                    a = (mpend.size() != 0) ? mpend.pop_front() : 32'hDEADBEEF;
                    if (m_drop > 0) m_drop--;
                    else mq.push_back('{a, imem_insn_i});
                end
                if (er) begin
                    mpend.push_back(m_fpc);
                    m_fpc = m_fpc + 32'd4;
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        nxt();
        redirect_i    = 1'b1;
        redirect_pc_i = tgt;
    endtask

    initial begin
        rst           = 1'b1;
        ready_i       = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_insn", insn_o, 32'd0);
        chk("rst_flush", perf_flush_cnt_o, 32'd0);
        chk("rst_starve", perf_starve_cnt_o, 32'd0);

        // Start-up latency and streaming
        rst = 1'b0;
        #1;
        chk("boot_req", {31'd0, imem_req_o}, 32'd1);
        chk("boot_addr", imem_addr_o, BASE);
        nxt(); #1;
        chk("boot_c2_valid", {31'd0, valid_o}, 32'd0);
        chk("boot_c2_addr", imem_addr_o, 32'h01000004);
        nxt(); #1;
        chk("boot_c3_valid", {31'd0, valid_o}, 32'd1);
        chk("boot_c3_pc", pc_o, 32'h01000000);
        chk("boot_c3_insn", insn_o, 32'hA4A5A5A5);
        nxt(); #1;
        chk("boot_c4_pc", pc_o, 32'h01000004);
        repeat (3) nxt();

        // Mid-stream reset, then back-pressure fill and drain
        rst = 1'b1;
        nxt();
        rst     = 1'b0;
        ready_i = 1'b0;
        #1;
        chk("rerst_valid", {31'd0, valid_o}, 32'd0);
        chk("rerst_addr", imem_addr_o, BASE);
`ifdef IFQ_PERF_EN
        chk("rerst_flush", perf_flush_cnt_o, 32'd0);
`endif
        repeat (6) nxt();
        #1;
        chk("full_req", {31'd0, imem_req_o}, 32'd0);
        chk("full_pc", pc_o, BASE);
        nxt();
        ready_i = 1'b1;
        #1;
        chk("drain_pc0", pc_o, BASE);
        for (int i = 1; i <= 4; i++) begin
            nxt(); #1;
            chk("drain_pc", pc_o, BASE + 32'(4 * i));
        end

        // Redirect with a 3-cycle refill
        redirect_to(32'h01000100);
        #1;
        chk("rd1_req", {31'd0, imem_req_o}, 32'd0);
        nxt();
        redirect_i = 1'b0;
        #1;
        chk("rd1_valid1", {31'd0, valid_o}, 32'd0);
        chk("rd1_addr", imem_addr_o, 32'h01000100);
        nxt(); #1;
        chk("rd1_valid2", {31'd0, valid_o}, 32'd0);
        nxt(); #1;
        chk("rd1_pc", pc_o, 32'h01000100);
        chk("rd1_insn", insn_o, 32'hA4A5A4A5);
`ifdef IFQ_PERF_EN
        chk("rd1_flush", perf_flush_cnt_o, 32'd1);
`endif

        // Misaligned redirect target
        redirect_to(32'h01000102);
        nxt();
        redirect_i = 1'b0;
        #1;
        chk("rd2_addr", imem_addr_o, 32'h01000100);
        repeat (2) nxt();
        #1;
        chk("rd2_pc", pc_o, 32'h01000100);

        // Back-to-back redirects: last one wins
        redirect_to(32'h01000200);
        nxt();
        redirect_pc_i = 32'h01000300;
        nxt();
        redirect_i = 1'b0;
        #1;
        chk("rd3_addr", imem_addr_o, 32'h01000300);
        chk("rd3_valid", {31'd0, valid_o}, 32'd0);
        nxt(); #1;
        chk("rd3_valid2", {31'd0, valid_o}, 32'd0);
        nxt(); #1;
        chk("rd3_pc", pc_o, 32'h01000300);
        nxt(); #1;
        chk("rd3_pc2", pc_o, 32'h01000304);
`ifdef IFQ_PERF_EN
        chk("rd3_flush", perf_flush_cnt_o, 32'd4);
`endif

        // Mixed back-pressure with occasional redirects, checked by the model
        for (int i = 0; i < 60; i++) begin
            nxt();
            ready_i       = (i % 3) != 1;
            redirect_i    = (i % 17) == 9;
            redirect_pc_i = 32'h02000000 + 32'(i * 64) + 32'(i % 4);
        end
        nxt();
        redirect_i = 1'b0;
        ready_i    = 1'b1;
        repeat (10) nxt();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
